// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_pkg
// Purpose  : Shared types for the memory-stage controller.
// Revision : 1.0
// ============================================================================
package mem_stage_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/ll_sc_link.sv
`default_nettype none
// ============================================================================
// Module   : ll_sc_link
// Purpose  : LL/SC link register with snoop invalidation and SC hit compare.
// Revision : 1.0
// ============================================================================
module ll_sc_link
    import mem_stage_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] aluout_i,
    input  logic              ll_done,
    input  logic              sc_done,
    input  logic              st_done,
    input  logic              halt_clr,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic              link_valid,
    output logic              link_hit
);

    // Only the word address matters, so the byte offset is never stored.
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:2] link_addr_q, link_addr_d;
    logic              unused_lsbs;

    assign unused_lsbs = ^{aluout_i[1:0], ccsnoopaddr[1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ll_done) begin
            link_valid_d = 1'b1;
            link_addr_d  = aluout_i[ADDR_W-1:2];
        end else if (sc_done) begin
            link_valid_d = 1'b0;
        end else if (st_done && (link_addr_q == aluout_i[ADDR_W-1:2])) begin
            link_valid_d = 1'b0;
        end else if (ccinv && (link_addr_q == ccsnoopaddr[ADDR_W-1:2])) begin
            link_valid_d = 1'b0;
        end else if (halt_clr) begin
            link_valid_d = 1'b0;
        end
    end

    // A snoop to the SC word in the deciding cycle must already fail the SC.
    assign link_hit = link_valid_q
                    & (link_addr_q == aluout_i[ADDR_W-1:2])
                    & ~(ccinv & (ccsnoopaddr[ADDR_W-1:2] == aluout_i[ADDR_W-1:2]));
    assign link_valid = link_valid_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage cache request/stall control, load hold and LL/SC link.
// Revision : 1.0
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int STALL_CW = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                dREN_i,
    input  logic                dWEN_i,
    input  logic                datomic_i,
    input  logic                halt_i,
    input  logic [ADDR_W-1:0]   aluout_i,
    input  logic [DATA_W-1:0]   rdat2_i,
    input  logic                pipe_adv,
    input  logic                dhit,
    input  logic [DATA_W-1:0]   dmemload,
    input  logic                ccinv,
    input  logic [ADDR_W-1:0]   ccsnoopaddr,
    output logic                dmemREN,
    output logic                dmemWEN,
    output logic [ADDR_W-1:0]   dmemaddr,
    output logic [DATA_W-1:0]   dmemstore,
    output logic                mem_stall,
    output logic [DATA_W-1:0]   load_data,
    output logic                halt_o,
    output logic                link_valid,
    output logic [STALL_CW-1:0] stall_cycles
);

    mem_state_t          state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [STALL_CW-1:0] stall_cycles_q, stall_cycles_d;
    logic                sc, sc_fail, mem_op, link_hit;
    logic                ll_done, sc_done, st_done, halt_clr;
    logic [DATA_W-1:0]   idle_data;

    assign sc        = datomic_i & dWEN_i;
    assign sc_fail   = sc & ~link_hit;
    assign mem_op    = dREN_i | (dWEN_i & ~sc_fail);
    assign dmemaddr  = aluout_i;
    assign dmemstore = rdat2_i;
    assign idle_data = dREN_i ? dmemload : {{(DATA_W-1){1'b0}}, sc & ~sc_fail};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        halt_o    = 1'b0;
        load_data = '0;
        ll_done   = 1'b0;
        sc_done   = 1'b0;
        st_done   = 1'b0;
        halt_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                dmemREN   = dREN_i;
                dmemWEN   = dWEN_i & ~sc_fail;
                mem_stall = mem_op & ~dhit;
                load_data = idle_data;
                if (mem_op && dhit) begin
                    ll_done = dREN_i & datomic_i;
                    sc_done = sc;
                    st_done = dWEN_i & ~datomic_i;
                    // Later stages frozen: keep the result so it is not re-fetched.
                    if (!pipe_adv) begin
                        hold_d  = idle_data;
                        state_d = HOLD;
                    end
                end else if (halt_i && !mem_op) begin
                    halt_clr = 1'b1;
                    state_d  = HALTED;
                end
            end
            HOLD: begin
                load_data = hold_q;
                if (pipe_adv) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                halt_o   = 1'b1;
                halt_clr = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (mem_stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + STALL_CW'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

    ll_sc_link u_link (
        .CLK         (CLK),
        .RST         (RST),
        .aluout_i    (aluout_i),
        .ll_done     (ll_done),
        .sc_done     (sc_done),
        .st_done     (st_done),
        .halt_clr    (halt_clr),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .link_valid  (link_valid),
        .link_hit    (link_hit)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed bench for mem_stage_ctrl with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          dREN_i = 1'b0, dWEN_i = 1'b0, datomic_i = 1'b0, halt_i = 1'b0;
    logic          pipe_adv = 1'b0, dhit = 1'b0, ccinv = 1'b0;
    logic [31:0]   aluout_i = '0, rdat2_i = '0, dmemload = '0, ccsnoopaddr = '0;
    logic          dmemREN, dmemWEN, mem_stall, halt_o, link_valid;
    logic [31:0]   dmemaddr, dmemstore, load_data;
    logic [CW-1:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.STALL_CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .dREN_i(dREN_i), .dWEN_i(dWEN_i), .datomic_i(datomic_i), .halt_i(halt_i),
        .aluout_i(aluout_i), .rdat2_i(rdat2_i), .pipe_adv(pipe_adv),
        .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .load_data(load_data), .halt_o(halt_o),
        .link_valid(link_valid), .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: abstract stage status, link word and stall tally.
    bit          m_halted, m_hold, m_lv, prev_rst = 1'b1;
    logic [31:0] m_hold_val, m_la;
    int          m_stalls;
    bit          n_halted, n_hold, n_lv;
    logic [31:0] n_hold_val, n_la;
    int          n_stalls;

    always @(negedge CLK) begin : model
        bit          e_ren, e_wen, e_stall, ld_ok, is_sc, sc_ok, is_ld, is_st, op, ll_fin;
        logic [31:0] e_ld;
        if (RST || prev_rst) begin
            m_halted = 0; m_hold = 0; m_hold_val = 0; m_lv = 0; m_la = 0; m_stalls = 0;
        end else begin
            m_halted = n_halted; m_hold = n_hold; m_hold_val = n_hold_val;
            m_lv = n_lv; m_la = n_la; m_stalls = n_stalls;
        end
        prev_rst = RST;
        n_halted = m_halted; n_hold = m_hold; n_hold_val = m_hold_val;
        n_lv = m_lv; n_la = m_la; n_stalls = m_stalls;
        e_ren = 0; e_wen = 0; e_stall = 0; ld_ok = 0; e_ld = 0; ll_fin = 0;
        is_sc = datomic_i && dWEN_i;
        if (m_halted) begin
            n_lv = 0;
        end else if (m_hold) begin
            ld_ok = 1;
            e_ld  = m_hold_val;
            if (pipe_adv) n_hold = 0;
        end else begin
            sc_ok = is_sc && m_lv && (m_la >> 2) == (aluout_i >> 2)
                    && !(ccinv && (ccsnoopaddr >> 2) == (aluout_i >> 2));
            is_ld = dREN_i;
            is_st = dWEN_i && (!is_sc || sc_ok);
            op    = is_ld || is_st;
            e_ren = is_ld;
            e_wen = is_st;
            e_stall = op && !dhit;
            if (is_ld) begin
                ld_ok = 1; e_ld = dmemload;
            end else if (is_sc) begin
                ld_ok = 1; e_ld = sc_ok ? 32'd1 : 32'd0;
            end
            if (op && dhit) begin
                if (!pipe_adv) begin
                    n_hold = 1; n_hold_val = e_ld;
                end
                if (is_ld && datomic_i) begin
                    n_lv = 1; n_la = aluout_i; ll_fin = 1;
                end else if (is_sc) begin
                    n_lv = 0;
                end else if (is_st && (m_la >> 2) == (aluout_i >> 2)) begin
                    n_lv = 0;
                end
            end else if (halt_i && !op) begin
                n_halted = 1; n_lv = 0;
            end
        end
        if (!ll_fin && ccinv && (ccsnoopaddr >> 2) == (m_la >> 2)) n_lv = 0;
        if (e_stall && m_stalls < (1 << CW) - 1) n_stalls = m_stalls + 1;

        check("m_dmemREN", {31'd0, dmemREN}, {31'd0, e_ren});
        check("m_dmemWEN", {31'd0, dmemWEN}, {31'd0, e_wen});
        check("m_mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
        check("m_halt_o", {31'd0, halt_o}, {31'd0, m_halted});
        check("m_link_valid", {31'd0, link_valid}, {31'd0, m_lv});
        check("m_stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        check("m_dmemaddr", dmemaddr, aluout_i);
        check("m_dmemstore", dmemstore, rdat2_i);
        if (ld_ok) check("m_load_data", load_data, e_ld);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic nop();
        dREN_i = 0; dWEN_i = 0; datomic_i = 0; halt_i = 0;
        dhit = 0; ccinv = 0; pipe_adv = 1;
    endtask

    task automatic set(input logic ren, input logic wen, input logic at,
                       input logic [31:0] addr, input logic hit, input logic adv);
        dREN_i = ren; dWEN_i = wen; datomic_i = at; aluout_i = addr;
        dhit = hit; pipe_adv = adv; ccinv = 0; halt_i = 0;
    endtask

    initial begin
        nop();
        pipe_adv = 0;
        RST = 1;
        repeat (2) step();
        settle();
        check("rst_link_valid", {31'd0, link_valid}, 32'd0);
        check("rst_halt_o", {31'd0, halt_o}, 32'd0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        step(); RST = 0;

        // Load, hit on the third cycle
        step(); set(1, 0, 0, 32'h100, 0, 0); dmemload = 32'h1234_5678; settle();
        check("ld_ren", {31'd0, dmemREN}, 32'd1);
        check("ld_stall", {31'd0, mem_stall}, 32'd1);
        step();
        step(); dhit = 1; pipe_adv = 1; settle();
        check("ld_data", load_data, 32'h1234_5678);
        check("ld_hit_nostall", {31'd0, mem_stall}, 32'd0);
        step(); nop(); settle();
        check("ld_stall_cnt", 32'(stall_cycles), 32'd2);

        // Load hit while frozen -> hold
        step(); set(1, 0, 0, 32'h104, 1, 0); dmemload = 32'hDEAD_BEEF;
        step(); set(1, 0, 0, 32'h104, 0, 0); dmemload = 32'h0; settle();
        check("hold_noreq", {31'd0, dmemREN}, 32'd0);
        check("hold_data1", load_data, 32'hDEAD_BEEF);
        step(); settle();
        check("hold_data2", load_data, 32'hDEAD_BEEF);
        step(); pipe_adv = 1; settle();
        check("hold_data3", load_data, 32'hDEAD_BEEF);
        step(); nop(); settle();
        check("hold_stall_cnt", 32'(stall_cycles), 32'd2);

        // LL then SC, no intervening events
        step(); set(1, 0, 1, 32'h200, 1, 1);
        step(); nop(); settle();
        check("ll_link", {31'd0, link_valid}, 32'd1);
        step(); set(0, 1, 1, 32'h200, 0, 0); rdat2_i = 32'h55; settle();
        check("sc_wen", {31'd0, dmemWEN}, 32'd1);
        check("sc_ok_data", load_data, 32'd1);
        check("sc_store", dmemstore, 32'h55);
        step(); dhit = 1; pipe_adv = 1;
        step(); nop(); settle();
        check("sc_unlink", {31'd0, link_valid}, 32'd0);

        // Snoop to the link word before the SC
        step(); set(1, 0, 1, 32'h200, 1, 1);
        step(); nop(); ccinv = 1; ccsnoopaddr = 32'h200;
        step(); set(0, 1, 1, 32'h200, 0, 1); settle();
        check("snp_sc_wen", {31'd0, dmemWEN}, 32'd0);
        check("snp_sc_stall", {31'd0, mem_stall}, 32'd0);
        check("snp_sc_data", load_data, 32'd0);
        // Snoop in the same cycle as the SC
        step(); set(1, 0, 1, 32'h200, 1, 1);
        step(); set(0, 1, 1, 32'h200, 0, 1); ccinv = 1; ccsnoopaddr = 32'h200; settle();
        check("snp_same_wen", {31'd0, dmemWEN}, 32'd0);
        check("snp_same_data", load_data, 32'd0);
        // Snoop to a neighbouring word leaves the link intact
        step(); set(1, 0, 1, 32'h200, 1, 1);
        step(); nop(); ccinv = 1; ccsnoopaddr = 32'h204;
        step(); set(0, 1, 1, 32'h200, 1, 1); settle();
        check("nbr_sc_wen", {31'd0, dmemWEN}, 32'd1);
        check("nbr_sc_data", load_data, 32'd1);

        // Plain store to the link word breaks the link
        step(); set(1, 0, 1, 32'h200, 1, 1);
        step(); set(0, 1, 0, 32'h200, 1, 1);
        step(); nop(); settle();
        check("sw_unlink", {31'd0, link_valid}, 32'd0);
        step(); set(0, 1, 1, 32'h200, 0, 1); settle();
        check("sw_sc_wen", {31'd0, dmemWEN}, 32'd0);
        check("sw_sc_data", load_data, 32'd0);

        // LL completing beats a same-cycle snoop; SC then held while frozen
        step(); set(1, 0, 1, 32'h300, 1, 1); ccinv = 1; ccsnoopaddr = 32'h300;
        step(); nop(); settle();
        check("ll_wins", {31'd0, link_valid}, 32'd1);
        step(); set(0, 1, 1, 32'h300, 1, 0);
        step(); set(0, 1, 1, 32'h300, 0, 0); settle();
        check("sc_hold_nowen", {31'd0, dmemWEN}, 32'd0);
        check("sc_hold_data", load_data, 32'd1);
        step(); pipe_adv = 1;
        step(); nop();

        // Stall counter saturation
        step(); set(1, 0, 0, 32'h400, 0, 0);
        repeat (20) step();
        settle();
        check("stall_sat", 32'(stall_cycles), 32'hF);
        step(); dhit = 1; pipe_adv = 1;

        // Halt
        step(); set(1, 0, 1, 32'h500, 1, 1);
        step(); nop(); halt_i = 1; settle();
        check("halt_not_yet", {31'd0, halt_o}, 32'd0);
        step(); settle();
        check("halt_set", {31'd0, halt_o}, 32'd1);
        check("halt_unlink", {31'd0, link_valid}, 32'd0);
        step(); set(1, 0, 0, 32'h600, 0, 0); settle();
        check("halt_noreq", {31'd0, dmemREN}, 32'd0);
        check("halt_nostall", {31'd0, mem_stall}, 32'd0);
        check("halt_sticky", {31'd0, halt_o}, 32'd1);
        step(); nop(); RST = 1; settle();
        check("halt_rst", {31'd0, halt_o}, 32'd0);
        step(); RST = 0;
        step(); set(1, 0, 0, 32'h700, 1, 1); dmemload = 32'hCAFE_F00D; settle();
        check("post_rst_ren", {31'd0, dmemREN}, 32'd1);
        check("post_rst_data", load_data, 32'hCAFE_F00D);
        step(); nop();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
